// File: rtl/hybrid_xform_pipe_if.sv
// hybrid_xform_pipe_if: input/output beat handshake bundle for hybrid_xform_pipe.
// master = upstream framer / downstream sink side, slave = the transform core.
interface hybrid_xform_pipe_if #(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 16
);
    localparam int OUT_W = DATA_W + 3;

    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            in_mode;
    logic [8*DATA_W-1:0]   in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [8*OUT_W-1:0]    out_data;
    logic                  out_mode_err;
    logic [CNT_W-1:0]      out_beat_cnt;

    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_mode_err, out_beat_cnt
    );

    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_data, out_mode_err, out_beat_cnt
    );
endinterface

// File: rtl/hybrid_xform_pipe.sv
// hybrid_xform_pipe: 8-lane streaming butterfly engine (WHT / Haar / bypass),
// three registered butterfly stages with a global stall enable.
// Optional feature macro: HYB_XFORM_SAT_EN clamps each result lane to the
// input sample range inside the last register stage.
module hybrid_xform_pipe #(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 16
) (
    input logic                CLK,
    input logic                RESET,
    hybrid_xform_pipe_if.slave bus
);
    localparam int OUT_W = DATA_W + 3;

    typedef logic signed [OUT_W-1:0] lane_t;
    typedef enum logic [1:0] {
        MODE_WHT  = 2'b00,
        MODE_HAAR = 2'b01,
        MODE_BYP  = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    // Lower lane of each butterfly pair per stage; partners are +1, +2, +4.
    localparam int unsigned S2_LO [4] = '{0, 1, 4, 5};

`ifdef HYB_XFORM_SAT_EN
    localparam lane_t SAT_MAX = lane_t'((1 << (DATA_W - 1)) - 1);
    localparam lane_t SAT_MIN = lane_t'(-(1 << (DATA_W - 1)));
`endif

    logic             en;
    mode_e            in_mode_e;
    lane_t            in_ext [8];
    lane_t            s1_d [8];
    lane_t            s2_d [8];
    lane_t            s3_r [8];
    lane_t            s3_d [8];
    lane_t            s1_q [8];
    lane_t            s2_q [8];
    lane_t            s3_q [8];
    logic             s1_vld_q, s2_vld_q, s3_vld_q;
    mode_e            s1_mode_q, s2_mode_q;
    logic             err_d, err_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    // Whole pipe advances unless the output beat is held by downstream.
    always_comb begin
        en        = !s3_vld_q || bus.out_ready;
        in_mode_e = mode_e'(bus.in_mode);
        err_d     = s2_vld_q && (s2_mode_q == MODE_RSVD);
    end

    // Stage 1 next-state: sign-extend lanes, adjacent-pair butterflies for WHT and Haar.
    always_comb begin
        for (int unsigned k = 0; k < 8; k++) begin
            in_ext[k] = lane_t'($signed(bus.in_data[k*DATA_W +: DATA_W]));
        end
        s1_d = in_ext;
        if (in_mode_e == MODE_WHT || in_mode_e == MODE_HAAR) begin
            for (int unsigned j = 0; j < 4; j++) begin
                s1_d[2*j]     = in_ext[2*j] + in_ext[2*j + 1];
                s1_d[2*j + 1] = in_ext[2*j] - in_ext[2*j + 1];
            end
        end
    end

    // Stage 2 next-state: distance-2 butterflies; Haar keeps only the low-pass pairs (0,2) and (4,6).
    always_comb begin
        s2_d = s1_q;
        for (int unsigned j = 0; j < 4; j++) begin
            if (s1_mode_q == MODE_WHT || (s1_mode_q == MODE_HAAR && (j == 0 || j == 2))) begin
                s2_d[S2_LO[j]]     = s1_q[S2_LO[j]] + s1_q[S2_LO[j] + 2];
                s2_d[S2_LO[j] + 2] = s1_q[S2_LO[j]] - s1_q[S2_LO[j] + 2];
            end
        end
    end

    // Stage 3 next-state: distance-4 butterflies (Haar only on (0,4)), then optional clamp.
    always_comb begin
        s3_r = s2_q;
        for (int unsigned j = 0; j < 4; j++) begin
            if (s2_mode_q == MODE_WHT || (s2_mode_q == MODE_HAAR && j == 0)) begin
                s3_r[j]     = s2_q[j] + s2_q[j + 4];
                s3_r[j + 4] = s2_q[j] - s2_q[j + 4];
            end
        end
`ifdef HYB_XFORM_SAT_EN
        for (int unsigned k = 0; k < 8; k++) begin
            if (s3_r[k] > SAT_MAX) begin
                s3_d[k] = SAT_MAX;
            end else if (s3_r[k] < SAT_MIN) begin
                s3_d[k] = SAT_MIN;
            end else begin
                s3_d[k] = s3_r[k];
            end
        end
`else
        s3_d = s3_r;
`endif
    end

    // Pipeline registers: bubbles travel with the beats, everything holds on stall.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            s3_vld_q  <= 1'b0;
            s1_mode_q <= MODE_WHT;
            s2_mode_q <= MODE_WHT;
            err_q     <= 1'b0;
            s1_q      <= '{default: '0};
            s2_q      <= '{default: '0};
            s3_q      <= '{default: '0};
        end else if (en) begin
            s1_vld_q  <= bus.in_valid;
            s2_vld_q  <= s1_vld_q;
            s3_vld_q  <= s2_vld_q;
            s1_mode_q <= in_mode_e;
            s2_mode_q <= s1_mode_q;
            err_q     <= err_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_q      <= s3_d;
        end
    end

    // Emitted-beat counter next-state: one step per downstream handshake, free wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (s3_vld_q && bus.out_ready) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Emitted-beat counter register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Output drive: stage 3 lanes packed onto the bus.
    always_comb begin
        bus.in_ready     = en;
        bus.out_valid    = s3_vld_q;
        bus.out_mode_err = err_q;
        bus.out_beat_cnt = cnt_q;
        bus.out_data     = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            bus.out_data[k*OUT_W +: OUT_W] = s3_q[k];
        end
    end
endmodule

// File: tb/tb_hybrid_xform_pipe.sv
// tb_hybrid_xform_pipe: scoreboard bench for hybrid_xform_pipe.
// Expected beats come from an arithmetic model (Hadamard sign matrix, Haar
// sums/differences) pushed at acceptance; observed beats are queued at the
// output handshake and each test task compares them inline.
module tb_hybrid_xform_pipe;
    localparam int DATA_W = 12;
    localparam int CNT_W  = 16;
    localparam int OUT_W  = DATA_W + 3;

    typedef logic [8*DATA_W-1:0] vec_t;
    typedef struct packed {
        logic               err;
        logic [8*OUT_W-1:0] data;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    bit    acc;
    beat_t exp_q[$];
    beat_t obs_q[$];
    int    exp_cyc[$];
    int    obs_cyc[$];

    hybrid_xform_pipe_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    hybrid_xform_pipe #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic beat_t model(input vec_t d, input logic [1:0] m);
        int    x[8];
        int    y[8];
        beat_t r;
        for (int k = 0; k < 8; k++) x[k] = $signed(d[k*DATA_W +: DATA_W]);
        case (m)
            2'b00: begin
                for (int k = 0; k < 8; k++) begin
                    y[k] = 0;
                    for (int j = 0; j < 8; j++) y[k] += ($countones(k & j) % 2 == 1) ? -x[j] : x[j];
                end
            end
            2'b01: begin
                y[0] = x[0] + x[1] + x[2] + x[3] + x[4] + x[5] + x[6] + x[7];
                y[4] = (x[0] + x[1] + x[2] + x[3]) - (x[4] + x[5] + x[6] + x[7]);
                y[2] = (x[0] + x[1]) - (x[2] + x[3]);
                y[6] = (x[4] + x[5]) - (x[6] + x[7]);
                y[1] = x[0] - x[1];
                y[3] = x[2] - x[3];
                y[5] = x[4] - x[5];
                y[7] = x[6] - x[7];
            end
            default: y = x;
        endcase
`ifdef HYB_XFORM_SAT_EN
        for (int k = 0; k < 8; k++) begin
            if (y[k] > (1 << (DATA_W - 1)) - 1) y[k] = (1 << (DATA_W - 1)) - 1;
            if (y[k] < -(1 << (DATA_W - 1)))    y[k] = -(1 << (DATA_W - 1));
        end
`endif
        r.err = (m == 2'b11);
        for (int k = 0; k < 8; k++) r.data[k*OUT_W +: OUT_W] = OUT_W'(y[k]);
        return r;
    endfunction

    function automatic vec_t mkvec(input int base, input int step);
        vec_t v;
        for (int k = 0; k < 8; k++) v[k*DATA_W +: DATA_W] = DATA_W'(base + step * k);
        return v;
    endfunction

    // Called at a falling edge with inputs driven; samples both handshakes, then advances one cycle.
    task automatic tick();
        #1;
        acc = bus.in_valid && bus.in_ready;
        if (acc) begin
            exp_q.push_back(model(bus.in_data, bus.in_mode));
            exp_cyc.push_back(cyc);
        end
        if (bus.out_valid && bus.out_ready) begin
            obs_q.push_back({bus.out_mode_err, bus.out_data});
            obs_cyc.push_back(cyc);
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] m, input vec_t d);
        bus.in_valid = 1'b1;
        bus.in_mode  = m;
        bus.in_data  = d;
        for (int n = 0; n < 50; n++) begin
            tick();
            if (acc) break;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 40 && (bus.out_valid || obs_q.size() < exp_q.size()); n++) tick();
    endtask

    task automatic flush_q();
        exp_q.delete(); obs_q.delete(); exp_cyc.delete(); obs_cyc.delete();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        flush_q();
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_mode   = 2'b00;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.out_mode_err !== 1'b0) begin bad++; $display("FAIL rst_mode_err: got %b want 0", bus.out_mode_err); end
        total++; if (bus.out_data !== '0) begin bad++; $display("FAIL rst_out_data: got %h want 0", bus.out_data); end
        total++; if (bus.out_beat_cnt !== '0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", bus.out_beat_cnt); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready: got %b want 1", bus.in_ready); end
        @(negedge clk);
        flush_q();
    endtask

    task automatic test_wht_haar();
        beat_t e, o;
        int    ec, oc;
        vec_t  imp;
        imp = '0;
        imp[DATA_W-1:0] = DATA_W'(1);
        bus.out_ready = 1'b1;
        send(2'b00, mkvec(1, 0));
        send(2'b00, imp);
        send(2'b01, mkvec(1, 1));
        drain();
        total++; if (obs_q.size() !== 3) begin bad++; $display("FAIL wht_count: got %0d want 3", obs_q.size()); end
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); ec = exp_cyc.pop_front(); oc = obs_cyc.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL wht_beat%0d: got err=%b data=%h want err=%b data=%h", i, o.err, o.data, e.err, e.data); end
            total++; if (oc - ec !== 3) begin bad++; $display("FAIL wht_latency%0d: got %0d want 3", i, oc - ec); end
            if (i == 0) begin
                total++; if (o.data[OUT_W-1:0] !== OUT_W'(8)) begin bad++; $display("FAIL ones_lane0: got %h want 8", o.data[OUT_W-1:0]); end
                total++; if (o.data[8*OUT_W-1:OUT_W] !== '0) begin bad++; $display("FAIL ones_lanes1_7: got %h want 0", o.data[8*OUT_W-1:OUT_W]); end
            end
            if (i == 2) begin
                total++; if (o.data[OUT_W-1:0] !== OUT_W'(36)) begin bad++; $display("FAIL haar_y0: got %h want 36", o.data[OUT_W-1:0]); end
                total++; if (o.data[4*OUT_W +: OUT_W] !== OUT_W'(-16)) begin bad++; $display("FAIL haar_y4: got %h want -16", o.data[4*OUT_W +: OUT_W]); end
            end
        end
        flush_q();
    endtask

    task automatic test_back_to_back();
        beat_t e, o;
        int    ec, oc, first;
        apply_reset();
        bus.out_ready = 1'b1;
        for (int m = 0; m < 4; m++) send(2'(m), vec_t'({$urandom(), $urandom(), $urandom()}));
        drain();
        total++; if (obs_q.size() !== 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", obs_q.size()); end
        first = (obs_cyc.size() > 0) ? obs_cyc[0] : 0;
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); ec = exp_cyc.pop_front(); oc = obs_cyc.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL b2b_beat%0d: got err=%b data=%h want err=%b data=%h", i, o.err, o.data, e.err, e.data); end
            total++; if (oc - ec !== 3) begin bad++; $display("FAIL b2b_latency%0d: got %0d want 3", i, oc - ec); end
            total++; if (oc - first !== i) begin bad++; $display("FAIL b2b_gap%0d: got offset %0d want %0d", i, oc - first, i); end
        end
        total++; if (bus.out_beat_cnt !== CNT_W'(4)) begin bad++; $display("FAIL b2b_cnt: got %0d want 4", bus.out_beat_cnt); end
        bus.out_ready = 1'b1;
        tick(); tick(); tick();
        total++; if (bus.out_beat_cnt !== CNT_W'(4)) begin bad++; $display("FAIL idle_ready_cnt: got %0d want 4", bus.out_beat_cnt); end
        flush_q();
    endtask

    task automatic test_stall();
        beat_t              e, o;
        logic [8*OUT_W-1:0] snap;
        bus.out_ready = 1'b0;
        send(2'b00, mkvec(3, -2));
        send(2'b01, mkvec(-7, 5));
        send(2'b10, mkvec(100, -33));
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid: got %b want 1", bus.out_valid); end
        snap = bus.out_data;
        bus.in_valid = 1'b1;
        bus.in_mode  = 2'b00;
        bus.in_data  = mkvec(9, 9);
        for (int n = 0; n < 5; n++) begin
            #1;
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready%0d: got %b want 0", n, bus.in_ready); end
            total++; if (bus.out_data !== snap) begin bad++; $display("FAIL stall_hold%0d: got %h want %h", n, bus.out_data, snap); end
            tick();
        end
        drain();
        total++; if (obs_q.size() !== 3) begin bad++; $display("FAIL stall_count: got %0d want 3", obs_q.size()); end
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL stall_beat%0d: got err=%b data=%h want err=%b data=%h", i, o.err, o.data, e.err, e.data); end
        end
        flush_q();
    endtask

    task automatic test_random();
        beat_t e, o;
        int    sent = 0;
        bus.in_mode = 2'(($urandom_range(0, 3)));
        bus.in_data = vec_t'({$urandom(), $urandom(), $urandom()});
        for (int n = 0; n < 200 && sent < 12; n++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            tick();
            if (acc) begin
                sent++;
                bus.in_mode = 2'($urandom_range(0, 3));
                bus.in_data = vec_t'({$urandom(), $urandom(), $urandom()});
            end
        end
        drain();
        total++; if (obs_q.size() !== 12) begin bad++; $display("FAIL rand_count: got %0d want 12", obs_q.size()); end
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL rand_beat%0d: got err=%b data=%h want err=%b data=%h", i, o.err, o.data, e.err, e.data); end
        end
        flush_q();
    endtask

    task automatic test_saturation();
        beat_t e, o;
        int    want0;
`ifdef HYB_XFORM_SAT_EN
        want0 = -2048;
`else
        want0 = -16384;
`endif
        bus.out_ready = 1'b1;
        send(2'b00, mkvec(-2048, 0));
        drain();
        total++; if (obs_q.size() !== 1) begin bad++; $display("FAIL sat_count: got %0d want 1", obs_q.size()); end
        if (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL sat_beat: got data=%h want data=%h", o.data, e.data); end
            total++; if (o.data[OUT_W-1:0] !== OUT_W'(want0)) begin bad++; $display("FAIL sat_lane0: got %h want %0d", o.data[OUT_W-1:0], want0); end
            total++; if (o.data[8*OUT_W-1:OUT_W] !== '0) begin bad++; $display("FAIL sat_lanes1_7: got %h want 0", o.data[8*OUT_W-1:OUT_W]); end
        end
        flush_q();
    endtask

    task automatic test_reset_midstream();
        beat_t e, o;
        int    ec, oc;
        bus.out_ready = 1'b0;
        send(2'b00, mkvec(5, 1));
        send(2'b01, mkvec(-3, 2));
        tick();
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid: got %b want 1", bus.out_valid); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.out_beat_cnt !== '0) begin bad++; $display("FAIL mid_rst_cnt: got %0d want 0", bus.out_beat_cnt); end
        @(negedge clk);
        rst = 1'b0;
        flush_q();
        bus.out_ready = 1'b1;
        send(2'b01, mkvec(1, 1));
        drain();
        total++; if (obs_q.size() !== 1) begin bad++; $display("FAIL mid_count: got %0d want 1", obs_q.size()); end
        if (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); ec = exp_cyc.pop_front(); oc = obs_cyc.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL mid_beat: got err=%b data=%h want err=%b data=%h", o.err, o.data, e.err, e.data); end
            total++; if (oc - ec !== 3) begin bad++; $display("FAIL mid_latency: got %0d want 3", oc - ec); end
        end
        total++; if (bus.out_beat_cnt !== CNT_W'(1)) begin bad++; $display("FAIL mid_cnt: got %0d want 1", bus.out_beat_cnt); end
        flush_q();
    endtask

    initial begin
        test_reset();
        test_wht_haar();
        test_back_to_back();
        test_stall();
        test_random();
        test_saturation();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
